// File: rtl/shift_iter_unit.sv
// Iterative 32-bit shifter: 5 SHIFT cycles per request (power-of-two steps 1..16), result held in DONE until taken.
// Accept-to-OUT_VALID latency 5 edges; one request in flight, IN_READY low from accept until the result hand-off.
module shift_iter_unit #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic             CLK,
   input  logic             RESET_N,
   input  logic             IN_VALID,
   output logic             IN_READY,
   input  logic             SH_DIR,
   input  logic [AMT_W-1:0] SH_AMT,
   input  logic [WIDTH-1:0] D_IN,
   output logic             OUT_VALID,
   input  logic             OUT_READY,
   output logic [WIDTH-1:0] D_OUT,
   output logic             BUSY
);

   localparam int STEP_W = $clog2(AMT_W);
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(AMT_W - 1);

   typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

   state_t            state;
   logic [STEP_W-1:0] step;
   logic [WIDTH-1:0]  work;
   logic [WIDTH-1:0]  work_nxt;
   logic [WIDTH-1:0]  fill;
   logic [WIDTH-1:0]  dout_q;
   logic [AMT_W-1:0]  amt_q;
   logic [AMT_W-1:0]  step_sz;
   logic              dir_q;
   logic              sign_q;
   logic              in_ready_q;
   logic              out_valid_q;
   logic              busy_q;

   // Sign fill comes from the operand's captured MSB, not the current working value.
   always_comb begin
      step_sz  = AMT_W'(1) << step;
      fill     = ~({WIDTH{1'b1}} >> step_sz) & {WIDTH{sign_q}};
      work_nxt = work;
      if (amt_q[step]) begin
         if (dir_q)
            work_nxt = (work >> step_sz) | fill;
         else
            work_nxt = work << step_sz;
      end
   end

   always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
         state       <= IDLE;
         step        <= '0;
         work        <= '0;
         dout_q      <= '0;
         amt_q       <= '0;
         dir_q       <= 1'b0;
         sign_q      <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (IN_VALID) begin
                  work       <= D_IN;
                  dir_q      <= SH_DIR;
                  amt_q      <= SH_AMT;
                  sign_q     <= D_IN[WIDTH-1];
                  step       <= '0;
                  state      <= SHIFT;
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
               end
            end
            SHIFT: begin
               work <= work_nxt;
               step <= step + STEP_W'(1);
               if (step == LAST_STEP) begin
                  dout_q      <= work_nxt;
                  out_valid_q <= 1'b1;
                  state       <= DONE;
               end
            end
            DONE: begin
               if (OUT_READY) begin
                  out_valid_q <= 1'b0;
                  in_ready_q  <= 1'b1;
                  busy_q      <= 1'b0;
                  state       <= IDLE;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign IN_READY  = in_ready_q;
   assign OUT_VALID = out_valid_q;
   assign D_OUT     = dout_q;
   assign BUSY      = busy_q;

endmodule
